// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: receive side of the 4-slot TDM link. Words arrive one slot at
// a time, slot 0 flagged by in_sof. Slots 0..2 are held in shadow registers
// and all four channels are published together when slot 3 arrives, so a
// consumer never sees a mix of two frames.
//
// state  | meaning
// S_HUNT | not aligned; waiting for a word with in_sof to start a frame
// S_RUN  | aligned; r_slot holds the slot index expected next
module tdm_demux_1x4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic             frame_valid,
   output logic             sync_err,
   output logic             locked
);

   typedef enum logic {
      S_HUNT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [1:0]       r_slot;
   logic [WIDTH-1:0] r_shadow0;
   logic [WIDTH-1:0] r_shadow1;
   logic [WIDTH-1:0] r_shadow2;
   logic [WIDTH-1:0] r_ch0;
   logic [WIDTH-1:0] r_ch1;
   logic [WIDTH-1:0] r_ch2;
   logic [WIDTH-1:0] r_ch3;
   logic             r_frame_valid;
   logic             r_sync_err;

   state_t           w_state_nxt;
   logic [1:0]       w_slot_nxt;
   logic             w_sh_we;
   logic [1:0]       w_sh_idx;
   logic             w_frame_done;
   logic             w_err;

   // State register and slot counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_HUNT;
         r_slot  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
      end
   end

   // Next-state, slot advance and datapath strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_slot_nxt   = r_slot;
      w_sh_we      = 1'b0;
      w_sh_idx     = r_slot;
      w_frame_done = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         S_HUNT: begin
            w_slot_nxt = 2'd0;
            if (in_valid && in_sof) begin
               w_sh_we     = 1'b1;
               w_sh_idx    = 2'd0;
               w_slot_nxt  = 2'd1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (in_valid) begin
               if (in_sof) begin
                  // sof at slot 0 is the normal case; anywhere else the
                  // partial frame is dropped and we realign on this word
                  w_err      = (r_slot != 2'd0);
                  w_sh_we    = 1'b1;
                  w_sh_idx   = 2'd0;
                  w_slot_nxt = 2'd1;
               end else if (r_slot == 2'd0) begin
                  w_err       = 1'b1;
                  w_slot_nxt  = 2'd0;
                  w_state_nxt = S_HUNT;
               end else if (r_slot == 2'd3) begin
                  w_frame_done = 1'b1;
                  w_slot_nxt   = 2'd0;
               end else begin
                  w_sh_we    = 1'b1;
                  w_slot_nxt = r_slot + 2'd1;
               end
            end
         end
         default: begin
            w_state_nxt = S_HUNT;
            w_slot_nxt  = 2'd0;
         end
      endcase
   end

   // Shadow capture of slots 0..2 while a frame is being assembled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow0 <= '0;
         r_shadow1 <= '0;
         r_shadow2 <= '0;
      end else if (w_sh_we) begin
         case (w_sh_idx)
            2'd0:    r_shadow0 <= in_data;
            2'd1:    r_shadow1 <= in_data;
            2'd2:    r_shadow2 <= in_data;
            default: ;
         endcase
      end
   end

   // Channel outputs publish a whole frame at once; status pulses last one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch0         <= '0;
         r_ch1         <= '0;
         r_ch2         <= '0;
         r_ch3         <= '0;
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
      end else begin
         r_frame_valid <= w_frame_done;
         r_sync_err    <= w_err;
         if (w_frame_done) begin
            r_ch0 <= r_shadow0;
            r_ch1 <= r_shadow1;
            r_ch2 <= r_shadow2;
            r_ch3 <= in_data;
         end
      end
   end

   assign ch0         = r_ch0;
   assign ch1         = r_ch1;
   assign ch2         = r_ch2;
   assign ch3         = r_ch3;
   assign frame_valid = r_frame_valid;
   assign sync_err    = r_sync_err;
   assign locked      = (r_state == S_RUN);

endmodule
